wb_trace_uart: RTL and testbench
================================

# wb_trace_uart

Write-back trace serializer that sits directly downstream of the pipelined RV32I core's write-back stage. It captures each retired write-back value (WB_OUT) together with the low byte of the fetch PC (NPC) into a small FIFO. It then streams each captured entry off-chip as a 5-byte UART 8N1 frame, so a host can check core execution on the board without a logic analyser.

## Interface
- CLK_DIV, 104: clock cycles per UART bit (104 ≈ 12 MHz / 115200); legal range ≥ 2.
- DEPTH, 8: FIFO entries; must be a power of two ≥ 2.
- clk  input  1  core clock; all state changes on the rising edge.
- RN  input  1  reset; one clock; asynchronous, active-high.
- wb_valid  input  1  capture strobe; one push per high cycle.
- wb_out  input  32  write-back value from the core (WB_OUT).
- npc  input  32  fetch PC from the core (NPC); only npc[7:0] is used.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while the serializer is outside IDLE.
- overflow  output  1  sticky flag: a capture was dropped because the FIFO was full.
- fifo_count  output  $clog2(DEPTH+1)  number of entries currently held.

## Operation
- **Entry format:** 40 bits {npc[7:0], wb_out[31:0]}, sampled on the rising edge where wb_valid=1.
- **Transmit order:** tag byte (npc[7:0]), then wb_out[31:24], [23:16], [15:8], [7:0].
- **FIFO:** circular buffer with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - Push when wb_valid=1 and not full.
  - Pop only when the FSM leaves IDLE.
- **Full handling:** a push while full and with no pop in the same cycle is dropped and sets overflow=1. overflow stays set until RN.
- **Push and pop in the same cycle:**
  - Both take effect.
  - fifo_count is unchanged.
  - A push while full is accepted if a pop occurs in the same cycle.
- **FSM states:** IDLE, START, DATA, STOP. Counters: baud counter 0..CLK_DIV-1, bit index 0..7, byte index 0..4.
  - IDLE: tx=1. If fifo_count>0, pop the head entry into a 40-bit shift register, set byte index to 0, and go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx = current byte bit[bit index], LSB first. Each bit lasts CLK_DIV cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles.
    - If byte index <4: increment byte index, shift the next byte in, and go to START (no gap between bytes).
    - If byte index =4: go to IDLE.
- **Output registering:** tx is a registered output, with no combinational path from the inputs.
- **busy:** busy = (state != IDLE).
- **Reset values:** tx=1, busy=0, overflow=0, fifo_count=0, FSM in IDLE, all pointers and counters 0.
- **Reset mid-frame:** tx goes to 1 immediately (asynchronously). The frame is abandoned and the FIFO contents are discarded. Nothing is resumed after reset.

## Timing
- **Capture to line:** capture on edge N with the FIFO empty and the FSM in IDLE. The pop and START entry occur on edge N+1, and tx falls from edge N+1.
- **Per byte:** 10·CLK_DIV cycles (start + 8 data + stop).
- **Per frame:** 50·CLK_DIV cycles.
- **Between frames:** exactly 1 IDLE cycle (tx=1) when the FIFO is non-empty. The next start bit begins 50·CLK_DIV+1 cycles after the previous one.
- **Throughput:** sustained wb_valid faster than one per (50·CLK_DIV+1) cycles eventually overflows. Dropping captures is the required behaviour; there is no back-pressure to the core.
- **fifo_count:** updates on the same edge as the push or pop.

## Test plan
- **Single frame.** Setup: CLK_DIV=4, one wb_valid pulse with npc=0x0000000A, wb_out=0x00000003. Required response: tx low from the next edge; decoded bytes 0x0A, 0x00, 0x00, 0x00, 0x03; each bit 4 cycles; frame 200 cycles; busy falls afterwards; fifo_count returns to 0.
- **Back-to-back frames.** Setup: CLK_DIV=4, two pulses on consecutive cycles (wb_out=0x11223344, then 0x55667788). Required response: two frames in order; second start bit exactly 201 cycles after the first.
- **Overflow.** Setup: DEPTH=4, wb_valid high for 6 consecutive cycles from the empty state. Required response: first entry popped on cycle 2; entries 1–5 transmitted; 6th dropped; overflow=1 and stays 1 after all frames finish.
- **Push while full with pop.** Setup: FIFO full, FSM finishing a STOP with byte index 4. Assert wb_valid in the cycle the FSM pops. Required response: push accepted; fifo_count stays DEPTH; overflow unchanged.
- **Reset mid-frame.** Setup: assert RN mid-DATA of byte 2 with 3 entries queued. Required response: tx=1, busy=0, fifo_count=0, overflow=0 immediately without a clock edge. After release, tx stays high until a new wb_valid.
- **Wrap-around.** Setup: push and drain 3·DEPTH+1 entries with distinct wb_out values. Required response: all frames are transmitted in push order across pointer wrap, with no overflow.

Source files
------------

// File: rtl/wb_trace_uart.sv
// -----------------------------------------------------------------------------
// wb_trace_uart
//
// Write-back trace serializer for the pipelined RV32I core. Every cycle the
// core retires a write-back (wb_valid=1) the block captures {npc[7:0], wb_out}
// into a small circular FIFO. A UART 8N1 transmitter drains the FIFO, sending
// each entry as five bytes: the PC tag byte first, then wb_out MSB to LSB.
//
// Parameters
//   CLK_DIV  clock cycles per UART bit (>= 2)
//   DEPTH    FIFO entries (power of two, >= 2)
//
// Ports
//   clk         core clock, rising edge
//   RN          asynchronous active-high reset
//   wb_valid    capture strobe, one push per high cycle
//   wb_out      write-back value (WB_OUT)
//   npc         fetch PC (NPC); only npc[7:0] is captured
//   tx          registered UART line, idle high
//   busy        serializer is outside IDLE
//   overflow    sticky: a capture was dropped because the FIFO was full
//   fifo_count  entries currently held
//   fsm_state   current serializer state (IDLE/START/DATA/STOP encoding)
//
// Handshake: wb_valid is a push-only strobe with no ready. A capture is
// accepted whenever the FIFO has room, or is full but pops on the same edge;
// otherwise it is dropped and overflow is set. The core is never stalled.
// -----------------------------------------------------------------------------
module wb_trace_uart #(
    parameter int CLK_DIV = 104,
    parameter int DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         RN,
    input  logic                         wb_valid,
    input  logic [31:0]                  wb_out,
    input  logic [31:0]                  npc,
    output logic                         tx,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [1:0]                   fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(CLK_DIV);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [2:0]    LAST_BYTE = 3'd4;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [39:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [1:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [2:0]    byte_idx;
    logic [39:0]   shreg;

    // Upper PC bits are not part of the trace entry.
    logic          unused_npc;
    assign unused_npc = ^npc[31:8];

    // ---------------------------------------------------------------------
    // FIFO control
    // ---------------------------------------------------------------------
    logic       full;
    logic       pop;
    logic       push;
    logic       drop;
    logic [7:0] cur_byte;
    logic [2:0] next_bit_idx;
    logic       baud_done;

    assign full = (fifo_count == CW'(DEPTH));
    // The serializer pops exactly on the edge it leaves IDLE.
    assign pop  = (state == ST_IDLE) && (fifo_count != '0);
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign push = wb_valid && (!full || pop);
    assign drop = wb_valid && full && !pop;

    // The byte on the wire always sits in the top 8 bits of the shifter.
    assign cur_byte     = shreg[39:32];
    assign next_bit_idx = bit_idx + 3'd1;
    assign baud_done    = (baud_cnt == BAUD_LAST);

    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    // Storage has no reset: contents are only meaningful between the
    // pointers, and those are cleared by RN.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {npc[7:0], wb_out};
        end
    end

    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Serializer FSM. tx is registered and assigned together with each
    // state transition, so the line level for a state appears on the same
    // edge that enters that state.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        // rd_ptr still addresses the head entry on this edge;
                        // a same-edge push to that slot lands afterwards.
                        shreg    <= mem[rd_ptr];
                        byte_idx <= '0;
                        baud_cnt <= '0;
                        state    <= ST_START;
                        tx       <= 1'b0;
                    end
                end

                ST_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                        tx       <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= next_bit_idx;
                            tx      <= cur_byte[next_bit_idx];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                ST_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (byte_idx < LAST_BYTE) begin
                            // Next byte starts with no idle gap.
                            byte_idx <= byte_idx + 3'd1;
                            shreg    <= {shreg[31:0], 8'h00};
                            state    <= ST_START;
                            tx       <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_trace_uart.sv
// -----------------------------------------------------------------------------
// tb_wb_trace_uart
//
// Bench for wb_trace_uart with CLK_DIV=4, DEPTH=4. A timeline reference model
// (FIFO queue plus "serializer free at cycle" bookkeeping) predicts accepted
// captures, fifo_count, busy, overflow and the exact tx level each cycle. A
// UART decoder reassembles frames from tx and checks them in order against
// the entries the model says were popped.
// -----------------------------------------------------------------------------
module tb_wb_trace_uart;

    localparam int CD    = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 50 * CD;
    localparam int CW    = $clog2(DEPTH + 1);

    // ---------------------------------------------------------------------
    // Clock / reset / DUT
    // ---------------------------------------------------------------------
    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          wb_valid = 1'b0;
    logic [31:0]   wb_out   = '0;
    logic [31:0]   npc      = '0;
    logic          tx;
    logic          busy;
    logic          overflow;
    logic [CW-1:0] fifo_count;
    logic [1:0]    fsm_state;

    always #5 clk = ~clk;

    wb_trace_uart #(.CLK_DIV(CD), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .RN         (rst),
        .wb_valid   (wb_valid),
        .wb_out     (wb_out),
        .npc        (npc),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count),
        .fsm_state  (fsm_state)
    );

    // ---------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ---------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // ---------------------------------------------------------------------
    // Reference model: a queue of held entries and the cycle from which the
    // serializer can take the next one (a frame occupies FRAME cycles plus
    // one IDLE cycle).
    // ---------------------------------------------------------------------
    logic [39:0] m_fifo[$];
    logic [39:0] exp_q[$];
    int          cyc        = 0;
    int          m_next_pop = 0;
    int          m_last_pop = -1000000;
    logic [39:0] m_cur      = '0;
    logic        m_ovf      = 1'b0;
    bit          m_do_pop;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_fifo.delete();
            exp_q.delete();
            m_next_pop = 0;
            m_last_pop = -1000000;
            m_ovf      = 1'b0;
        end else begin
            m_do_pop = (m_fifo.size() > 0) && (cyc >= m_next_pop);
            if (m_do_pop) begin
                m_cur = m_fifo.pop_front();
                exp_q.push_back(m_cur);
                m_last_pop = cyc;
                m_next_pop = cyc + FRAME + 1;
            end
            if (wb_valid) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back({npc[7:0], wb_out});
                else                       m_ovf = 1'b1;
            end
        end
    end

    function automatic logic m_busy();
        return (cyc - m_last_pop) < FRAME;
    endfunction

    // Line level from position inside the frame: 10 bit-slots per byte,
    // slot 0 start, slots 1..8 data LSB first, slot 9 stop.
    function automatic logic m_tx();
        int o, b, seg;
        if (!m_busy()) return 1'b1;
        o   = cyc - m_last_pop;
        b   = o / (10 * CD);
        seg = (o % (10 * CD)) / CD;
        if (seg == 0) return 1'b0;
        if (seg == 9) return 1'b1;
        return m_cur[(4 - b) * 8 + seg - 1];
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("cyc_fifo_count", 64'(fifo_count), 64'(m_fifo.size()));
        check("cyc_busy", busy, m_busy());
        check("cyc_overflow", overflow, m_ovf);
        check("cyc_tx", tx, m_tx());
    end

    // ---------------------------------------------------------------------
    // UART decoder: samples the middle of each bit slot.
    // ---------------------------------------------------------------------
    bit          mon_active  = 0;
    int          mon_t       = 0;
    int          mon_b, mon_r;
    logic [39:0] mon_data    = '0;
    logic [39:0] last_frame  = '0;
    int          frames_seen = 0;
    int          start_q[$];

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 0;
            mon_t      = 0;
        end else begin
            if (!mon_active && tx === 1'b0) begin
                mon_active = 1;
                mon_t      = 0;
                mon_data   = '0;
                start_q.push_back(cyc);
            end
            if (mon_active) begin
                mon_b = mon_t / (10 * CD);
                mon_r = mon_t % (10 * CD);
                if (mon_r == CD / 2)
                    check("start_bit", tx, 1'b0);
                else if (mon_r == 9 * CD + CD / 2)
                    check("stop_bit", tx, 1'b1);
                else if (mon_r % CD == CD / 2)
                    mon_data[(4 - mon_b) * 8 + mon_r / CD - 1] = tx;
                if (mon_t == FRAME - 1) begin
                    mon_active = 0;
                    frames_seen++;
                    last_frame = mon_data;
                    check("frame_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) check("frame_data", mon_data, exp_q.pop_front());
                end else begin
                    mon_t++;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Driver tasks (inputs change on the falling edge)
    // ---------------------------------------------------------------------
    task automatic drive(input logic v, input logic [31:0] n, input logic [31:0] w);
        @(negedge clk);
        wb_valid = v;
        npc      = n;
        wb_out   = w;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, $urandom, $urandom);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((m_fifo.size() != 0 || m_busy()) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) timeout_fail("drain");
        idle(2);
    endtask

    task automatic wait_cycle(input int target, input int budget);
        int k = 0;
        while (cyc != target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) timeout_fail("wait_cycle");
    endtask

    // ---------------------------------------------------------------------
    // Directed single-frame vectors
    // ---------------------------------------------------------------------
    typedef struct {
        logic [31:0] npc;
        logic [31:0] wb;
        logic [39:0] frame;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int f0, s0, target;
        logic [31:0] n1, n2;

        vecs[0] = '{32'h0000_000A, 32'h0000_0003, 40'h0A_0000_0003};
        vecs[1] = '{32'h1234_5678, 32'hDEAD_BEEF, 40'h78_DEAD_BEEF};
        vecs[2] = '{32'hFFFF_FF00, 32'hFFFF_FFFF, 40'h00_FFFF_FFFF};
        vecs[3] = '{32'h0000_00FF, 32'h8000_0001, 40'hFF_8000_0001};

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_count", 64'(fifo_count), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(5);

        // Single frames from the table
        for (int i = 0; i < 4; i++) begin
            f0 = frames_seen;
            drive(1'b1, vecs[i].npc, vecs[i].wb);
            drive(1'b0, $urandom, $urandom);
            check("tbl_count_after_push", 64'(fifo_count), 64'd1);
            check("tbl_tx_idle_at_capture", tx, 1'b1);
            drive(1'b0, $urandom, $urandom);
            check("tbl_tx_start", tx, 1'b0);
            check("tbl_busy", busy, 1'b1);
            check("tbl_count_after_pop", 64'(fifo_count), 64'd0);
            wait_drain(400);
            check("tbl_frame_cnt", 64'(frames_seen - f0), 64'd1);
            check("tbl_frame", last_frame, vecs[i].frame);
            check("tbl_busy_end", busy, 1'b0);
        end

        // Back-to-back frames
        s0 = start_q.size();
        n1 = $urandom;
        n2 = $urandom;
        drive(1'b1, n1, 32'h1122_3344);
        drive(1'b1, n2, 32'h5566_7788);
        drive(1'b0, $urandom, $urandom);
        wait_drain(800);
        check("b2b_starts", 64'(start_q.size() - s0), 64'd2);
        if (start_q.size() - s0 == 2)
            check("b2b_gap", 64'(start_q[s0 + 1] - start_q[s0]), 64'(FRAME + 1));
        check("b2b_last", last_frame, {n2[7:0], 32'h5566_7788});

        // Push while full, on the edge the serializer pops
        f0 = frames_seen;
        for (int i = 0; i < 5; i++) drive(1'b1, $urandom, $urandom);
        drive(1'b0, $urandom, $urandom);
        check("pwf_full", 64'(fifo_count), 64'(DEPTH));
        wait_cycle(m_next_pop - 1, 1000);
        wb_valid = 1'b1;
        npc      = $urandom;
        wb_out   = $urandom;
        @(negedge clk);
        wb_valid = 1'b0;
        check("pwf_count", 64'(fifo_count), 64'(DEPTH));
        check("pwf_overflow", overflow, 1'b0);
        wait_drain(1500);
        check("pwf_frames", 64'(frames_seen - f0), 64'd6);

        // Overflow: six consecutive captures into DEPTH=4
        f0 = frames_seen;
        for (int i = 0; i < 6; i++) drive(1'b1, $urandom, 32'hA000_0000 + 32'(i));
        drive(1'b0, $urandom, $urandom);
        check("ovf_set", overflow, 1'b1);
        check("ovf_count", 64'(fifo_count), 64'(DEPTH));
        wait_drain(1500);
        check("ovf_frames", 64'(frames_seen - f0), 64'd5);
        check("ovf_last", last_frame[31:0], 32'hA000_0004);
        check("ovf_sticky", overflow, 1'b1);

        // Reset in the middle of byte 2 with three entries queued
        f0 = frames_seen;
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h0, 32'h0);
        drive(1'b0, $urandom, $urandom);
        target = m_last_pop + 23 * CD + 1;
        wait_cycle(target, 100);
        check("rmf_pre_tx", tx, 1'b0);
        check("rmf_pre_count", 64'(fifo_count), 64'd3);
        #1 rst = 1'b1;
        #1;
        check("rmf_tx", tx, 1'b1);
        check("rmf_busy", busy, 1'b0);
        check("rmf_count", 64'(fifo_count), 64'd0);
        check("rmf_overflow", overflow, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(60);
        check("rmf_tx_after", tx, 1'b1);
        check("rmf_no_frame", 64'(frames_seen - f0), 64'd0);

        // Wrap-around: 3*DEPTH+1 distinct entries, never overflowing
        f0 = frames_seen;
        for (int i = 0; i < 3 * DEPTH + 1; i++) begin
            begin
                int k = 0;
                while (m_fifo.size() >= DEPTH && k < 2000) begin
                    @(negedge clk);
                    k++;
                end
                if (k >= 2000) timeout_fail("wrap_space");
            end
            drive(1'b1, $urandom, {8'(i), 24'($urandom)});
            drive(1'b0, $urandom, $urandom);
            idle($urandom_range(0, 30));
        end
        wait_drain(5000);
        check("wrap_frames", 64'(frames_seen - f0), 64'(3 * DEPTH + 1));
        check("wrap_overflow", overflow, 1'b0);

        // Random traffic with drops
        repeat (3000) drive($urandom_range(0, 99) < 4, $urandom, $urandom);
        drive(1'b0, $urandom, $urandom);
        wait_drain(3000);
        check("rand_sb_empty", 64'(exp_q.size()), 64'd0);
        check("rand_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

endmodule
